// File: rtl/game_pkg.sv
// Shared geometry, colour codes and dropper state encoding for the falling-block game.
// The stack stage and the renderer import the same constants.
package game_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int BLOCK_W  = 32;
    localparam int BLOCK_H  = 16;

    typedef enum logic [1:0] {
        COLOR_NONE = 2'd0,
        COLOR_1    = 2'd1,
        COLOR_2    = 2'd2,
        COLOR_3    = 2'd3
    } color_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPAWN = 2'd1,
        ST_FALL  = 2'd2,
        ST_WAIT  = 2'd3
    } drop_state_t;

    // Values past x_max wrap back to the left edge so every spawn stays on screen.
    function automatic logic [9:0] spawn_x(input logic [9:0] c, input logic [9:0] x_max);
        return (c <= x_max) ? c : (c - x_max - 10'd1);
    endfunction

    function automatic color_t spawn_color(input logic [1:0] bits);
        return (bits == 2'd0) ? COLOR_1 : color_t'(bits);
    endfunction

endpackage

// File: rtl/block_dropper_if.sv
// Dropper-to-stack-stage bundle: frame tick and stack feedback in, falling block out.
interface block_dropper_if;
    import game_pkg::*;

    logic        tick;
    logic        run;
    logic [9:0]  stack_x;
    logic [9:0]  stack_top_y;
    logic [9:0]  fall_x;
    logic [9:0]  fall_y;
    color_t      fall_color;
    logic        active;
    logic        caught;
    logic        missed;

    modport master (
        input  tick, run, stack_x, stack_top_y,
        output fall_x, fall_y, fall_color, active, caught, missed
    );

    modport slave (
        output tick, run, stack_x, stack_top_y,
        input  fall_x, fall_y, fall_color, active, caught, missed
    );

endinterface

// File: rtl/block_dropper_lfsr10.sv
// Free-running 10-bit Fibonacci LFSR, x^10 + x^7 + 1, maximal length (1023 states).
module lfsr10 #(
    parameter logic [9:0] SEED = 10'h2A5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] q
);

    logic [9:0] q_q;
    logic [9:0] q_d;

    always_comb begin
        q_d = {q_q[8:0], q_q[9] ^ q_q[6]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/block_dropper.sv
// Spawns one falling block at a time, steps it down on frame ticks and reports
// whether it landed on the stack top (caught) or on the floor (missed).
module block_dropper
    import game_pkg::*;
#(
    parameter int         FALL_STEP     = 2,
    parameter int         RESPAWN_TICKS = 30,
    parameter logic [9:0] LFSR_SEED     = 10'h2A5
) (
    input  logic            clk,
    input  logic            rst,
    block_dropper_if.master bus
);

    localparam logic [9:0]  X_MAX      = 10'(SCREEN_W - BLOCK_W);
    localparam logic [9:0]  BH10       = 10'(BLOCK_H);
    localparam logic [10:0] BH11       = 11'(BLOCK_H);
    localparam logic [10:0] BW11       = 11'(BLOCK_W);
    localparam logic [10:0] STEP11     = 11'(FALL_STEP);
    localparam logic [10:0] FLOOR11    = 11'(SCREEN_H);
    localparam logic [9:0]  FLOOR_REST = 10'(SCREEN_H - BLOCK_H);
    localparam int          CNT_W      = $clog2(RESPAWN_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESPAWN_TICKS - 1);

    drop_state_t      state_q, state_d;
    logic [9:0]       fall_x_q, fall_x_d;
    logic [9:0]       fall_y_q, fall_y_d;
    color_t           color_q, color_d;
    logic             active_q, active_d;
    logic             caught_q, caught_d;
    logic             missed_q, missed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [9:0]  lfsr;
    logic        tick_en;
    logic [10:0] ny;
    logic [10:0] diff;
    logic [10:0] abs_diff;
    logic        overlap;
    logic        hit_stack;
    logic        hit_floor;
    logic [9:0]  catch_y;

    lfsr10 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    assign tick_en   = bus.tick & bus.run;
    assign ny        = {1'b0, fall_y_q} + STEP11;
    // 11-bit two's complement keeps the full -1023..1023 x separation exact.
    assign diff      = {1'b0, fall_x_q} - {1'b0, bus.stack_x};
    assign abs_diff  = diff[10] ? (~diff + 11'd1) : diff;
    assign overlap   = abs_diff < BW11;
    assign hit_stack = ((ny + BH11) >= {1'b0, bus.stack_top_y}) && overlap;
    assign hit_floor = (ny + BH11) >= FLOOR11;
    assign catch_y   = (bus.stack_top_y >= BH10) ? (bus.stack_top_y - BH10) : 10'd0;

    always_comb begin
        state_d  = state_q;
        fall_x_d = fall_x_q;
        fall_y_d = fall_y_q;
        color_d  = color_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        caught_d = 1'b0;
        missed_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (tick_en) begin
                    state_d = ST_SPAWN;
                end
            end
            ST_SPAWN: begin
                fall_x_d = spawn_x(lfsr, X_MAX);
                fall_y_d = 10'd0;
                color_d  = spawn_color(lfsr[1:0]);
                active_d = 1'b1;
                state_d  = ST_FALL;
            end
            ST_FALL: begin
                if (tick_en) begin
                    // Landing on the stack wins when the floor is reached on the same tick.
                    if (hit_stack) begin
                        fall_y_d = catch_y;
                        caught_d = 1'b1;
                        active_d = 1'b0;
                        state_d  = ST_WAIT;
                    end else if (hit_floor) begin
                        fall_y_d = FLOOR_REST;
                        missed_d = 1'b1;
                        active_d = 1'b0;
                        state_d  = ST_WAIT;
                    end else begin
                        fall_y_d = ny[9:0];
                    end
                end
            end
            ST_WAIT: begin
                if (tick_en) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_SPAWN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            fall_x_q <= '0;
            fall_y_q <= '0;
            color_q  <= COLOR_NONE;
            active_q <= 1'b0;
            caught_q <= 1'b0;
            missed_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            fall_x_q <= fall_x_d;
            fall_y_q <= fall_y_d;
            color_q  <= color_d;
            active_q <= active_d;
            caught_q <= caught_d;
            missed_q <= missed_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.fall_x     = fall_x_q;
    assign bus.fall_y     = fall_y_q;
    assign bus.fall_color = color_q;
    assign bus.active     = active_q;
    assign bus.caught     = caught_q;
    assign bus.missed     = missed_q;

endmodule

// File: tb/tb_block_dropper.sv
// Randomised bench for block_dropper: stimulus queues expected spawn/landing events
// computed from block geometry; a negedge monitor pops and compares them.
module tb_block_dropper;
    import game_pkg::*;

    localparam int FALL_STEP = 2;
    localparam int RESPAWN   = 30;
    localparam int SEED      = 'h2A5;

    typedef struct {
        int kind;   // 0 spawn, 1 caught, 2 missed
        int cyc;
        int x;
        int y;
        int color;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    block_dropper_if bus ();

    block_dropper #(
        .FALL_STEP     (FALL_STEP),
        .RESPAWN_TICKS (RESPAWN),
        .LFSR_SEED     (10'h2A5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   m_lfsr = 0;
    logic prev_active = 1'b0;
    ev_t  exp_q[$];
    int   cur_fx, cur_col, cur_sx, cur_st;

    function automatic int lfsr_step(input int v);
        return ((v << 1) & 1023) | (((v >> 9) ^ (v >> 6)) & 1);
    endfunction

    function automatic int xmap(input int c);
        return (c <= SCREEN_W - BLOCK_W) ? c : c - (SCREEN_W - BLOCK_W) - 1;
    endfunction

    function automatic int cmap(input int c);
        return ((c & 3) == 0) ? 1 : (c & 3);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input int x, input int y, input int col);
        ev_t e;
        e.kind = kind; e.cyc = c; e.x = x; e.y = y; e.color = col;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        m_lfsr <= rst ? SEED : lfsr_step(m_lfsr);
    end

    task automatic check_event(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d at cyc %0d, required none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            $display("event kind=%0d cyc=%0d x=%0d y=%0d color=%0d", kind, cyc,
                     bus.fall_x, bus.fall_y, bus.fall_color);
            chk("ev_kind", kind, e.kind);
            chk("ev_cyc", cyc, e.cyc);
            chk("ev_x", int'(bus.fall_x), e.x);
            chk("ev_y", int'(bus.fall_y), e.y);
            chk("ev_color", int'(bus.fall_color), e.color);
            chk("ev_active", int'(bus.active), int'(kind == 0));
        end
    endtask

    always @(negedge clk) begin
        chk("pulse_excl", int'(bus.caught & bus.missed), 0);
        if (bus.active && !prev_active) check_event(0);
        if (bus.caught) check_event(1);
        if (bus.missed) check_event(2);
        prev_active <= bus.active;
    end

    // Called at a negedge; tick is high for exactly the next rising edge.
    task automatic tick_once(input bit r);
        bus.run         = r;
        bus.stack_x     = 10'(cur_sx);
        bus.stack_top_y = 10'(cur_st);
        bus.tick        = 1'b1;
        @(negedge clk);
        bus.tick        = 1'b0;
        bus.run         = 1'($urandom);
        bus.stack_x     = 10'($urandom);
        bus.stack_top_y = 10'($urandom);
    endtask

    task automatic spawn_tick();
        int nl;
        nl      = lfsr_step(m_lfsr);
        cur_fx  = xmap(nl);
        cur_col = cmap(nl);
        push_ev(0, cyc + 2, cur_fx, 0, cur_col);
        tick_once(1'b1);
        if ($urandom_range(0, 1) == 1) tick_once(1'b1);
        else @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst      = 1'b1;
        bus.tick = 1'b1;
        bus.run  = 1'b1;
        @(negedge clk);
        chk("rst_outputs", int'({bus.fall_x, bus.fall_y, bus.fall_color,
                                 bus.active, bus.caught, bus.missed}), 0);
        chk("rst_pending", exp_q.size(), 0);
        rst      = 1'b0;
        bus.tick = 1'b0;
    endtask

    // Outcome from geometry: first tick whose new bottom edge reaches stack top or floor.
    task automatic fall_block(input int dx, input int top, input int reset_at);
        int sx, n, nc, kind, y, t;
        bit ov;
        sx = cur_fx + dx;
        if (sx < 0) sx = 0;
        if (sx > 1023) sx = 1023;
        cur_sx = sx;
        cur_st = top;
        ov   = ((cur_fx - sx) < BLOCK_W) && ((sx - cur_fx) < BLOCK_W);
        t    = top - BLOCK_H;
        n    = (SCREEN_H - BLOCK_H + FALL_STEP - 1) / FALL_STEP;
        kind = 2;
        y    = SCREEN_H - BLOCK_H;
        if (ov) begin
            nc = (t <= 0) ? 1 : (t + FALL_STEP - 1) / FALL_STEP;
            if (nc <= n) begin
                n    = nc;
                kind = 1;
                y    = (t < 0) ? 0 : t;
            end
        end
        $display("block x=%0d stack_x=%0d top=%0d -> kind=%0d after %0d ticks", cur_fx, sx, top, kind, n);
        for (int k = 1; k <= n; k++) begin
            if ($urandom_range(0, 7) == 0) tick_once(1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (k == n) begin
                push_ev(kind, cyc + 1, cur_fx, y, cur_col);
                tick_once(1'b1);
            end else begin
                tick_once(1'b1);
                chk("fall_y", int'(bus.fall_y), FALL_STEP * k);
                if (k == reset_at) begin
                    pulse_reset();
                    return;
                end
            end
        end
    endtask

    task automatic wait_respawn();
        for (int i = 1; i <= RESPAWN; i++) begin
            if ($urandom_range(0, 3) == 0) tick_once(1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (i == RESPAWN) begin
                spawn_tick();
            end else begin
                tick_once(1'b1);
                chk("wait_active", int'(bus.active), 0);
            end
        end
    endtask

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int dxs[9] = '{0, 10, -10, 31, -31, 32, -32, 100, -300};
        int targets[3] = '{608, 609, 1023};
        int exp_x[3]   = '{608, 0, 414};
        int exp_c[3]   = '{1, 1, 3};
        int w, top;

        rst = 1'b1;
        bus.tick = 1'b1;
        bus.run = 1'b1;
        bus.stack_x = '0;
        bus.stack_top_y = '0;
        cur_sx = 0;
        cur_st = 0;
        repeat (5) begin
            @(negedge clk);
            chk("reset_outputs", int'({bus.fall_x, bus.fall_y, bus.fall_color,
                                       bus.active, bus.caught, bus.missed}), 0);
        end
        rst = 1'b0;
        bus.tick = 1'b0;
        @(negedge clk);

        // Directed: catch, miss at the overlap edge, catch just inside it.
        spawn_tick();
        fall_block(10, 100, 0);
        wait_respawn();
        fall_block(32, 100, 0);
        wait_respawn();
        fall_block(31, 100, 0);
        wait_respawn();

        for (int b = 0; b < 10; b++) begin
            top = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(20, 500);
            fall_block(dxs[$urandom_range(0, 8)], top, 0);
            wait_respawn();
        end

        // Reset while falling at y=40, then a clean respawn from IDLE.
        fall_block(300, 100, 20);
        repeat (3) @(negedge clk);
        chk("post_reset_idle_active", int'(bus.active), 0);
        spawn_tick();
        fall_block(10, 100, 0);

        for (int i = 0; i < 3; i++) begin
            pulse_reset();
            w = 0;
            while (lfsr_step(m_lfsr) != targets[i] && w < 1100) begin
                @(negedge clk);
                w++;
            end
            chk("lfsr_reached", int'(w < 1100), 1);
            spawn_tick();
            chk("x_map", int'(bus.fall_x), exp_x[i]);
            chk("x_color", int'(bus.fall_color), exp_c[i]);
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
